demux_stream_1n: RTL
====================

// Module: demux_stream_1n
// PURPOSE
//  Parametrised 1:N stream demultiplexer with registered, flow-controlled outputs.
//  It steers each input beat to one output channel chosen by in_sel. In broadcast mode it sends the beat to all channels.
//  Each output channel has a one-entry holding register with a valid/ready handshake.
//  It sits between a single producer and N independent consumers in the datapath.
// PARAMETERS
//  WIDTH   8   data width of every beat in bits
//  N_OUT   4   number of output channels, >=2, need not be a power of two
//  CNT_W   16  width of the saturating drop counter
//  SEL_W   $clog2(N_OUT) (localparam)  width of in_sel
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            input beat present
//  in_ready   out  1            block accepts the beat this cycle
//  in_data    in   WIDTH        input beat
//  in_sel     in   SEL_W        destination channel, used when bcast=0
//  bcast      in   1            1 = copy the beat to all N_OUT channels
//  out_valid  out  N_OUT        per-channel beat valid
//  out_ready  in   N_OUT        per-channel consumer ready
//  out_data   out  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  err_sel    out  1            one-cycle pulse when a beat with in_sel>=N_OUT is dropped
//  drop_cnt   out  CNT_W        count of dropped beats, saturates at all-ones
// BEHAVIOUR
//  - Reset: async assert on rst_n=0. out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
//    Reset mid-operation discards all held beats. No beat is emitted after rst_n rises until a new accept occurs.
//  - Slot k is free when !out_valid[k] || out_ready[k]. A slot that drains in a cycle can refill in that same cycle.
//  - Addressed mode (bcast=0, in_sel<N_OUT): in_ready = free[in_sel].
//    On in_valid&&in_ready, slot in_sel loads in_data and sets out_valid[in_sel] at the next edge.
//  - Broadcast mode (bcast=1): in_ready = AND of free[k] over all k.
//    On accept, all slots load in_data together. There are no partial broadcasts.
//  - Illegal select (bcast=0, in_sel>=N_OUT, only possible when N_OUT is not a power of two):
//    in_ready=1 and the beat is consumed and dropped. err_sel=1 on the next cycle. drop_cnt increments and saturates.
//  - Latency: accept at edge t means out_valid is seen high after edge t. No combinational path from in_data to out_data.
//  - A slot that is not completing a handshake holds its out_data and out_valid stable: out_valid && !out_ready means no change.
//  - A slot that is not loading and completes a handshake (out_valid && out_ready) clears out_valid.
//  - out_data of an empty slot keeps its last value. Verification must not check it.
//  - in_ready may depend combinationally on out_ready, in_sel and bcast. It must not depend on in_valid.
//  - Sustained throughput is 1 beat/cycle per channel while the consumer holds out_ready=1.
//  - When in_valid=0, in_sel and bcast are don't-care. No state changes except drains.
// STRUCTURE
//  - Package demux_pkg holds the function sel_legal(sel, n) and the localparam rule SEL_W = (N_OUT>1) ? $clog2(N_OUT) : 1.
//  - Sub-module demux_slot (WIDTH): a one-entry valid/ready register stage with ports
//    clk, rst_n, load, d, q, valid, ready, free. It is instantiated N_OUT times in a generate loop.
//  - The top level contains only the select decode, in_ready logic, error pulse and saturating counter.
// TESTING
//  1. Reset 0->1, then in_valid=1, in_sel=2, in_data=8'hA5, all out_ready=1.
//     Expect out_valid=4'b0100 and channel 2 data=A5 one cycle later. Other channels stay 0.
//  2. out_ready[1]=0 and two beats sent to sel=1 (8'h11 then 8'h22).
//     The first is held. in_ready=0 on the second until out_ready[1]=1. Then 8'h22 appears the cycle after 8'h11 drains.
//  3. bcast=1, data=8'h3C, out_ready=4'b1011 with channel 2 full.
//     Expect in_ready=0 and no slot loaded. Raise out_ready[2]: all four slots show 3C next cycle.
//  4. N_OUT=5, in_sel=3'd6, in_valid=1.
//     Expect in_ready=1, no out_valid change, err_sel pulses once, drop_cnt goes from 0 to 1.
//     Force drop_cnt to saturate with CNT_W=2: it stays at 3.
//  5. Back-to-back traffic, sel cycling 0..3 with all ready.
//     Expect one beat per cycle accepted and each channel receives its beats in order.
//  6. Assert rst_n=0 asynchronously mid-cycle with slots 0 and 3 full.
//     Expect out_valid=0 immediately, and nothing emitted after release until a new accept.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared helpers for the 1:N stream demultiplexer.
package demux_pkg;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic sel_legal(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry valid/ready holding register for a single output channel.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    input  logic             ready,
    output logic             free
);

    assign free = !valid || ready;

    // load wins over drain so a draining slot can refill in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_1n.sv
// demux_stream_1n: 1:N stream demultiplexer with broadcast, registered outputs
// and a saturating counter of beats dropped for an out-of-range select.
module demux_stream_1n
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int CNT_W = 16,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   bcast,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   err_sel,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [N_OUT-1:0] hit;
    logic [N_OUT-1:0] free;
    logic             legal;
    logic             drop;

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_OUT; k++) hit[k] = bcast || (32'(in_sel) == k);
    end

    assign legal    = sel_legal(32'(in_sel), N_OUT);
    assign in_ready = bcast ? &free : legal ? |(free & hit) : 1'b1;
    assign drop     = in_valid && !bcast && !legal;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (in_valid && in_ready && hit[k]),
            .d     (in_data),
            .q     (out_data[k*WIDTH +: WIDTH]),
            .valid (out_valid[k]),
            .ready (out_ready[k]),
            .free  (free[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_sel <= drop;
            if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
